// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - LIFO stack for decoder push/pop requests
// Popped word and status are registered; pushes are visible to a pop in the next cycle.
module stack_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             pushEn,
  input  logic             popEn,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] popData,
  output logic             popValid,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clearErr
);

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             push;
  logic             pop;
  logic             do_write;
  logic             do_replace;
  logic             do_pop;
  logic             ovf_set;
  logic             unf_set;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // Requests are masked by freeze so a stalled cycle behaves as idle.
  assign push = pushEn && !freeze;
  assign pop  = popEn  && !freeze;

  assign wr_idx  = count[AW-1:0];
  // Only consumed when the stack is non-empty, so the modulo wrap never matters.
  assign top_idx = wr_idx - IDX_ONE;

  assign do_write   = push && !pop && !full;
  assign do_replace = push && pop && !empty;
  assign do_pop     = pop && (push || !empty);
  assign ovf_set    = push && !pop && full;
  assign unf_set    = pop && !push && empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_write) begin
        mem[wr_idx] <= pushData;
      end else if (do_replace) begin
        mem[top_idx] <= pushData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      popData   <= '0;
      popValid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      popValid <= do_pop;
      if (do_pop) begin
        // Push+pop on an empty stack forwards the pushed word straight through.
        popData <= empty ? pushData : mem[top_idx];
      end
      if (do_write) begin
        count <= count + CNT_ONE;
      end else if (pop && !push && !empty) begin
        count <= count - CNT_ONE;
      end
      overflow  <= !clearErr && (overflow  || ovf_set);
      underflow <= !clearErr && (underflow || unf_set);
    end
  end

endmodule
